// File: rtl/syn_fgyrus_butterfly_if.sv
// rtl/syn_fgyrus_butterfly_if.sv - sample/twiddle input and result output bus of the fgyrus butterfly
interface syn_fgyrus_butterfly_if #(
    parameter int SAMPLE_W = 32,
    parameter int TWDL_W   = 10
);
    logic signed [SAMPLE_W-1:0] sample_a_real;
    logic signed [SAMPLE_W-1:0] sample_a_im;
    logic signed [SAMPLE_W-1:0] sample_b_real;
    logic signed [SAMPLE_W-1:0] sample_b_im;
    logic signed [TWDL_W-1:0]   twdl_real;
    logic signed [TWDL_W-1:0]   twdl_im;
    logic                       samples_rdy;
    logic                       err_clr;
    logic signed [SAMPLE_W-1:0] data_real;
    logic signed [SAMPLE_W-1:0] data_im;
    logic                       data_rdy;
    logic                       butter_busy;
    logic                       butter_err;

    modport master (
        output sample_a_real, sample_a_im, sample_b_real, sample_b_im,
        output twdl_real, twdl_im, samples_rdy, err_clr,
        input  data_real, data_im, data_rdy, butter_busy, butter_err
    );

    modport slave (
        input  sample_a_real, sample_a_im, sample_b_real, sample_b_im,
        input  twdl_real, twdl_im, samples_rdy, err_clr,
        output data_real, data_im, data_rdy, butter_busy, butter_err
    );
endinterface

// File: rtl/syn_fgyrus_butterfly.sv
// rtl/syn_fgyrus_butterfly.sv - radix-2 DIT butterfly, X0 = A+B*W then X1 = A-B*W, 3-cycle latency
// Optional output saturation: define SYN_FGYRUS_BUTTER_SAT_EN (default build wraps to SAMPLE_W bits).
module syn_fgyrus_butterfly #(
    parameter int SAMPLE_W = 32,
    parameter int TWDL_W   = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    syn_fgyrus_butterfly_if.slave  bus
);
    localparam int PW = SAMPLE_W + TWDL_W + 1;
    localparam int SH = TWDL_W - 2;
    localparam int XW = SAMPLE_W + 1;

    // Stage 1: registered inputs
    logic                       s1_valid;
    logic signed [SAMPLE_W-1:0] a_r1, a_i1, b_r1, b_i1;
    logic signed [TWDL_W-1:0]   w_r1, w_i1;
    // Stage 2: full-precision product and delayed A
    logic                       s2_valid;
    logic signed [SAMPLE_W-1:0] a_r2, a_i2;
    logic signed [PW-1:0]       pr2, pi2;
    // Stage 3: output registers and the held second result
    logic signed [SAMPLE_W-1:0] data_real_q, data_im_q, x1_r_q, x1_i_q;
    logic                       data_rdy_q, x1_pend, err_q;

    logic accept, reject;
    assign accept = bus.samples_rdy && !s1_valid;
    assign reject = bus.samples_rdy && s1_valid;

    logic signed [PW-1:0] br_x, bi_x, wr_x, wi_x, pr_c, pi_c;
    assign br_x = {{(PW-SAMPLE_W){b_r1[SAMPLE_W-1]}}, b_r1};
    assign bi_x = {{(PW-SAMPLE_W){b_i1[SAMPLE_W-1]}}, b_i1};
    assign wr_x = {{(PW-TWDL_W){w_r1[TWDL_W-1]}}, w_r1};
    assign wi_x = {{(PW-TWDL_W){w_i1[TWDL_W-1]}}, w_i1};
    assign pr_c = br_x * wr_x - bi_x * wi_x;
    assign pi_c = br_x * wi_x + bi_x * wr_x;

    // Slicing above SH is the arithmetic right shift (floor) of the scaled product
    logic signed [XW-1:0] p_r, p_i, a_rx, a_ix, x0_r, x0_i, x1_r, x1_i;
    assign p_r  = pr2[SH+XW-1:SH];
    assign p_i  = pi2[SH+XW-1:SH];
    assign a_rx = {a_r2[SAMPLE_W-1], a_r2};
    assign a_ix = {a_i2[SAMPLE_W-1], a_i2};
    assign x0_r = a_rx + p_r;
    assign x0_i = a_ix + p_i;
    assign x1_r = a_rx - p_r;
    assign x1_i = a_ix - p_i;

    logic signed [SAMPLE_W-1:0] y0_r, y0_i, y1_r, y1_i;
    always_comb begin
        y0_r = x0_r[SAMPLE_W-1:0];
        y0_i = x0_i[SAMPLE_W-1:0];
        y1_r = x1_r[SAMPLE_W-1:0];
        y1_i = x1_i[SAMPLE_W-1:0];
`ifdef SYN_FGYRUS_BUTTER_SAT_EN
        // Top two bits disagree only when the SAMPLE_W+1 result is out of range
        if (x0_r[XW-1] != x0_r[XW-2]) y0_r = x0_r[XW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        if (x0_i[XW-1] != x0_i[XW-2]) y0_i = x0_i[XW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        if (x1_r[XW-1] != x1_r[XW-2]) y1_r = x1_r[XW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        if (x1_i[XW-1] != x1_i[XW-2]) y1_i = x1_i[XW-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
`endif
    end

    logic unused_bits;
    assign unused_bits = ^{pr2[PW-1:SH+XW], pr2[SH-1:0], pi2[PW-1:SH+XW], pi2[SH-1:0],
                           x0_r[XW-1], x0_i[XW-1], x1_r[XW-1], x1_i[XW-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            a_r1 <= '0; a_i1 <= '0; b_r1 <= '0; b_i1 <= '0;
            w_r1 <= '0; w_i1 <= '0;
            s2_valid <= 1'b0;
            a_r2 <= '0; a_i2 <= '0; pr2 <= '0; pi2 <= '0;
            data_real_q <= '0; data_im_q <= '0; data_rdy_q <= 1'b0;
            x1_r_q <= '0; x1_i_q <= '0; x1_pend <= 1'b0;
            err_q <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                a_r1 <= bus.sample_a_real;
                a_i1 <= bus.sample_a_im;
                b_r1 <= bus.sample_b_real;
                b_i1 <= bus.sample_b_im;
                w_r1 <= bus.twdl_real;
                w_i1 <= bus.twdl_im;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                a_r2 <= a_r1;
                a_i2 <= a_i1;
                pr2  <= pr_c;
                pi2  <= pi_c;
            end

            // Accepted pairs are at least 2 cycles apart, so s2_valid and x1_pend never coincide
            data_rdy_q <= 1'b0;
            if (s2_valid) begin
                data_real_q <= y0_r;
                data_im_q   <= y0_i;
                x1_r_q      <= y1_r;
                x1_i_q      <= y1_i;
                x1_pend     <= 1'b1;
                data_rdy_q  <= 1'b1;
            end else if (x1_pend) begin
                data_real_q <= x1_r_q;
                data_im_q   <= x1_i_q;
                x1_pend     <= 1'b0;
                data_rdy_q  <= 1'b1;
            end

            if (reject)
                err_q <= 1'b1;
            else if (bus.err_clr)
                err_q <= 1'b0;
        end
    end

    assign bus.data_real   = data_real_q;
    assign bus.data_im     = data_im_q;
    assign bus.data_rdy    = data_rdy_q;
    assign bus.butter_busy = s1_valid;
    assign bus.butter_err  = err_q;
endmodule

// File: tb/tb_syn_fgyrus_butterfly.sv
// tb/tb_syn_fgyrus_butterfly.sv - directed self-checking bench for syn_fgyrus_butterfly
module tb_syn_fgyrus_butterfly;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    syn_fgyrus_butterfly_if #(.SAMPLE_W(32), .TWDL_W(10)) bus ();

    syn_fgyrus_butterfly #(.SAMPLE_W(32), .TWDL_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic signed [31:0] ar, ai, br, bi, input logic signed [9:0] wr, wi);
        bus.sample_a_real = ar;
        bus.sample_a_im   = ai;
        bus.sample_b_real = br;
        bus.sample_b_im   = bi;
        bus.twdl_real     = wr;
        bus.twdl_im       = wi;
        bus.samples_rdy   = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        total_cnt++;
        if ({bus.data_real, bus.data_im} !== 64'd0) $display("FAIL reset_data: got %h/%h want 0/0", bus.data_real, bus.data_im);
        else pass_cnt++;
        total_cnt++;
        if ({bus.data_rdy, bus.butter_busy, bus.butter_err} !== 3'b000)
            $display("FAIL reset_flags: got rdy/busy/err=%b%b%b want 000", bus.data_rdy, bus.butter_busy, bus.butter_err);
        else pass_cnt++;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_real_multiply(input string tag);
        drive(32'sd100, 32'sd0, 32'sd50, 32'sd0, 10'sd256, 10'sd0);    // cycle N
        step();                                                          // N+1
        bus.samples_rdy = 1'b0;
        total_cnt++;
        if (bus.butter_busy !== 1'b1) $display("FAIL %s_busy_n1: got %b want 1", tag, bus.butter_busy);
        else pass_cnt++;
        step();                                                          // N+2
        total_cnt++;
        if ({bus.butter_busy, bus.data_rdy} !== 2'b00) $display("FAIL %s_n2: got busy/rdy=%b%b want 00", tag, bus.butter_busy, bus.data_rdy);
        else pass_cnt++;
        step();                                                          // N+3
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== 32'sd150 || bus.data_im !== 32'sd0)
            $display("FAIL %s_x0: got rdy=%b (%0d,%0d) want 1 (150,0)", tag, bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();                                                          // N+4
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== 32'sd50 || bus.data_im !== 32'sd0)
            $display("FAIL %s_x1: got rdy=%b (%0d,%0d) want 1 (50,0)", tag, bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();                                                          // N+5
        total_cnt++;
        if (bus.data_rdy !== 1'b0 || bus.data_real !== 32'sd50)
            $display("FAIL %s_hold: got rdy=%b real=%0d want 0 50", tag, bus.data_rdy, bus.data_real);
        else pass_cnt++;
    endtask

    task automatic test_minus_j();
        drive(32'sd0, 32'sd0, 32'sd10, 32'sd20, 10'sd0, -10'sd256);
        step();
        bus.samples_rdy = 1'b0;
        step();
        step();
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== 32'sd20 || bus.data_im !== -32'sd10)
            $display("FAIL minus_j_x0: got rdy=%b (%0d,%0d) want 1 (20,-10)", bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== -32'sd20 || bus.data_im !== 32'sd10)
            $display("FAIL minus_j_x1: got rdy=%b (%0d,%0d) want 1 (-20,10)", bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();
    endtask

    task automatic test_overflow();
        logic [31:0] exp_x0;
`ifdef SYN_FGYRUS_BUTTER_SAT_EN
        exp_x0 = 32'h7FFFFFFF;
`else
        exp_x0 = 32'h800000F0;
`endif
        drive(32'sh7FFFFFF0, 32'sd0, 32'sh100, 32'sd0, 10'sd256, 10'sd0);
        step();
        bus.samples_rdy = 1'b0;
        step();
        step();
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== exp_x0 || bus.data_im !== 32'sd0)
            $display("FAIL overflow_x0: got rdy=%b %h/%h want 1 %h/0", bus.data_rdy, bus.data_real, bus.data_im, exp_x0);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== 32'h7FFFFEF0 || bus.data_im !== 32'sd0)
            $display("FAIL overflow_x1: got rdy=%b %h/%h want 1 7ffffef0/0", bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();
    endtask

    task automatic test_truncation();
        drive(32'sd0, 32'sd0, -32'sd1, 32'sd0, 10'sd128, 10'sd0);
        step();
        bus.samples_rdy = 1'b0;
        step();
        step();
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== -32'sd1 || bus.data_im !== 32'sd0)
            $display("FAIL trunc_x0: got rdy=%b (%0d,%0d) want 1 (-1,0)", bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.data_rdy !== 1'b1 || bus.data_real !== 32'sd1 || bus.data_im !== 32'sd0)
            $display("FAIL trunc_x1: got rdy=%b (%0d,%0d) want 1 (1,0)", bus.data_rdy, bus.data_real, bus.data_im);
        else pass_cnt++;
        step();
    endtask

    task automatic test_back_to_back();
        logic signed [31:0] exp_r [4] = '{32'sd4, -32'sd2, 32'sd15, 32'sd5};
        logic signed [31:0] exp_i [4] = '{32'sd6, -32'sd2, 32'sd0, 32'sd0};
        drive(32'sd1, 32'sd2, 32'sd3, 32'sd4, 10'sd256, 10'sd0);          // N accepted
        step();
        total_cnt++;
        if (bus.butter_busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", bus.butter_busy);
        else pass_cnt++;
        drive(32'sd999, 32'sd999, 32'sd999, 32'sd999, 10'sd256, 10'sd256); // N+1 rejected
        step();
        total_cnt++;
        if ({bus.butter_err, bus.butter_busy} !== 2'b10) $display("FAIL b2b_err_set: got err/busy=%b%b want 10", bus.butter_err, bus.butter_busy);
        else pass_cnt++;
        drive(32'sd10, 32'sd0, 32'sd5, 32'sd0, 10'sd256, 10'sd0);         // N+2 accepted
        step();
        bus.samples_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin                                   // N+3..N+6
            total_cnt++;
            if (bus.data_rdy !== 1'b1 || bus.data_real !== exp_r[k] || bus.data_im !== exp_i[k])
                $display("FAIL b2b_out%0d: got rdy=%b (%0d,%0d) want 1 (%0d,%0d)", k, bus.data_rdy, bus.data_real, bus.data_im, exp_r[k], exp_i[k]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (bus.data_rdy !== 1'b0 || bus.butter_err !== 1'b1) $display("FAIL b2b_end: got rdy/err=%b%b want 01", bus.data_rdy, bus.butter_err);
        else pass_cnt++;
        // Rejection and clear in the same cycle: the set must win
        drive(32'sd0, 32'sd0, 32'sd0, 32'sd0, 10'sd0, 10'sd0);
        step();
        bus.err_clr = 1'b1;
        step();
        bus.samples_rdy = 1'b0;
        bus.err_clr = 1'b0;
        total_cnt++;
        if (bus.butter_err !== 1'b1) $display("FAIL err_set_wins: got %b want 1", bus.butter_err);
        else pass_cnt++;
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        total_cnt++;
        if (bus.butter_err !== 1'b0) $display("FAIL err_clr: got %b want 0", bus.butter_err);
        else pass_cnt++;
        repeat (4) step();
    endtask

    task automatic test_reset_in_flight();
        bit seen_rdy = 1'b0;
        drive(32'sd7, 32'sd7, 32'sd7, 32'sd7, 10'sd256, 10'sd0);           // N
        step();
        bus.samples_rdy = 1'b0;
        step();                                                            // N+2
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({bus.data_real, bus.data_im} !== 64'd0 || {bus.data_rdy, bus.butter_busy, bus.butter_err} !== 3'b000)
            $display("FAIL rst_flight_outputs: got %h/%h rdy/busy/err=%b%b%b want all 0", bus.data_real, bus.data_im, bus.data_rdy, bus.butter_busy, bus.butter_err);
        else pass_cnt++;
        step();
        step();                                                            // N+4
        rst = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (bus.data_rdy !== 1'b0) seen_rdy = 1'b1;
            step();
        end
        total_cnt++;
        if (seen_rdy !== 1'b0) $display("FAIL rst_flight_no_rdy: got data_rdy seen=%b want 0", seen_rdy);
        else pass_cnt++;
        test_real_multiply("after_rst");
    endtask

    initial begin
        bus.sample_a_real = '0; bus.sample_a_im = '0;
        bus.sample_b_real = '0; bus.sample_b_im = '0;
        bus.twdl_real = '0; bus.twdl_im = '0;
        bus.samples_rdy = 1'b0; bus.err_clr = 1'b0;
        test_reset();
        test_real_multiply("real_mult");
        test_minus_j();
        test_overflow();
        test_truncation();
        test_back_to_back();
        test_reset_in_flight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
